// File: rtl/mult_div_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// RV32M funct3 decode, controller states and the divide special-case constants.
package mult_div_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_WAIT = 3'd1,
        S_DIV_WAIT = 3'd2,
        S_RESULT   = 3'd3,
        S_DRAIN    = 3'd4
    } state_e;

    // RISC-V mandated results: x/0 gives all ones, INT_MIN/-1 overflows back to INT_MIN.
    localparam logic [31:0] MULDIV_DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] MULDIV_INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] MULDIV_NEG_ONE   = 32'hFFFF_FFFF;

endpackage

// File: rtl/mult_div_ctrl_if.sv
// Bundle of RS, multiplier, divider and CDB signals around the mult/div sequencer.
// master is the sequencer side; slave is the surrounding pipeline and arithmetic units.
interface mult_div_ctrl_if #(
    parameter int TAG_W = 2
);

    logic             flush;
    logic             comp_issue;
    logic [31:0]      instr_in;
    logic [TAG_W-1:0] tag_dest_in;
    logic [31:0]      data_A_in;
    logic [31:0]      data_B_in;
    logic             resp;

    logic             mul_start;
    logic             mul_a_signed;
    logic             mul_b_signed;
    logic             mul_done;
    logic [63:0]      mul_product;

    logic             div_start;
    logic             div_signed;
    logic             div_done;
    logic [31:0]      div_quot;
    logic [31:0]      div_rem;

    logic [31:0]      op_a;
    logic [31:0]      op_b;

    logic             cdb_req;
    logic             cdb_gnt;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;

    modport master (
        input  flush, comp_issue, instr_in, tag_dest_in, data_A_in, data_B_in,
        input  mul_done, mul_product, div_done, div_quot, div_rem, cdb_gnt,
        output resp, mul_start, mul_a_signed, mul_b_signed, div_start, div_signed,
        output op_a, op_b, cdb_req, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        output flush, comp_issue, instr_in, tag_dest_in, data_A_in, data_B_in,
        output mul_done, mul_product, div_done, div_quot, div_rem, cdb_gnt,
        input  resp, mul_start, mul_a_signed, mul_b_signed, div_start, div_signed,
        input  op_a, op_b, cdb_req, cdb_valid, cdb_tag, cdb_data
    );

endinterface

// File: rtl/mult_div_special.sv
// Divide special cases resolved without the divider: divide-by-zero and signed overflow.
// Purely combinational; only meaningful when funct3 selects a divide/remainder op.
module mult_div_special
    import mult_div_pkg::*;
(
    input  funct3_e     funct3_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        is_special_o,
    output logic [31:0] special_result_o
);

    logic div_op;
    logic rem_op;
    logic signed_op;
    logic div_by_zero;
    logic overflow;

    assign div_op      = funct3_i[2];
    assign rem_op      = funct3_i[1];
    assign signed_op   = !funct3_i[0];
    assign div_by_zero = div_op && (b_i == '0);
    assign overflow    = div_op && signed_op && (a_i == MULDIV_INT_MIN) && (b_i == MULDIV_NEG_ONE);

    always_comb begin
        is_special_o     = div_by_zero || overflow;
        special_result_o = '0;
        if (div_by_zero) begin
            special_result_o = rem_op ? a_i : MULDIV_DIV0_QUOT;
        end else if (overflow) begin
            special_result_o = rem_op ? '0 : a_i;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer between the mult/div reservation station and the multi-cycle mul/div units.
// One op in flight: decode, start the unit (or resolve locally), win the CDB, retire.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter  int ROB_DEPTH = 4,
    localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
    input logic             clk,
    input logic             rst,
    mult_div_ctrl_if.master bus
);

    state_e           state_q, state_d;
    funct3_e          funct3_q, funct3_d;
    funct3_e          funct3_in;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [31:0]      result_q, result_d;
    logic             start_q, start_d;
    logic             drain_div_q, drain_div_d;
    logic             mul_a_signed_q, mul_a_signed_d;
    logic             mul_b_signed_q, mul_b_signed_d;
    logic             div_signed_q, div_signed_d;
    logic             is_special;
    logic [31:0]      special_result;
    logic             cdb_req_w;
    logic             unused_instr_bits;

    assign funct3_in         = funct3_e'(bus.instr_in[14:12]);
    assign unused_instr_bits = ^{bus.instr_in[31:15], bus.instr_in[11:0]};

    mult_div_special u_special (
        .funct3_i         (funct3_in),
        .a_i              (bus.data_A_in),
        .b_i              (bus.data_B_in),
        .is_special_o     (is_special),
        .special_result_o (special_result)
    );

    always_comb begin
        // NOTE: every _d starts from its _q (or an explicit 0), so no branch below can infer a latch.
        state_d        = state_q;
        funct3_d       = funct3_q;
        tag_d          = tag_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        result_d       = result_q;
        start_d        = 1'b0;
        drain_div_d    = drain_div_q;
        mul_a_signed_d = mul_a_signed_q;
        mul_b_signed_d = mul_b_signed_q;
        div_signed_d   = div_signed_q;

        case (state_q)
            S_IDLE: begin
                if (bus.comp_issue && !bus.flush) begin
                    funct3_d       = funct3_in;
                    tag_d          = bus.tag_dest_in;
                    op_a_d         = bus.data_A_in;
                    op_b_d         = bus.data_B_in;
                    mul_a_signed_d = funct3_in inside {F3_MUL, F3_MULH, F3_MULHSU};
                    mul_b_signed_d = funct3_in inside {F3_MUL, F3_MULH};
                    div_signed_d   = funct3_in inside {F3_DIV, F3_REM};
                    if (!funct3_in[2]) begin
                        state_d = S_MUL_WAIT;
                        start_d = 1'b1;
                    end else if (is_special) begin
                        state_d  = S_RESULT;
                        result_d = special_result;
                    end else begin
                        state_d = S_DIV_WAIT;
                        start_d = 1'b1;
                    end
                end
            end
            // A flush during the start cycle means the unit never saw a start, so nothing to drain.
            S_MUL_WAIT: begin
                if (bus.flush) begin
                    state_d     = (start_q || bus.mul_done) ? S_IDLE : S_DRAIN;
                    drain_div_d = 1'b0;
                end else if (bus.mul_done) begin
                    result_d = (funct3_q == F3_MUL) ? bus.mul_product[31:0] : bus.mul_product[63:32];
                    state_d  = S_RESULT;
                end
            end
            S_DIV_WAIT: begin
                if (bus.flush) begin
                    state_d     = (start_q || bus.div_done) ? S_IDLE : S_DRAIN;
                    drain_div_d = 1'b1;
                end else if (bus.div_done) begin
                    result_d = funct3_q[1] ? bus.div_rem : bus.div_quot;
                    state_d  = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.flush || bus.cdb_gnt) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (drain_div_q ? bus.div_done : bus.mul_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: rst is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
        if (rst) begin
            state_q        <= S_IDLE;
            funct3_q       <= F3_MUL;
            tag_q          <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            start_q        <= 1'b0;
            drain_div_q    <= 1'b0;
            mul_a_signed_q <= 1'b0;
            mul_b_signed_q <= 1'b0;
            div_signed_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q        <= state_d;
            funct3_q       <= funct3_d;
            tag_q          <= tag_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            result_q       <= result_d;
            start_q        <= start_d;
            drain_div_q    <= drain_div_d;
            mul_a_signed_q <= mul_a_signed_d;
            mul_b_signed_q <= mul_b_signed_d;
            div_signed_q   <= div_signed_d;
        end
    end

    // flush silences every request and pulse in the cycle it is asserted.
    assign cdb_req_w        = (state_q == S_RESULT) && !bus.flush;
    assign bus.cdb_req      = cdb_req_w;
    assign bus.cdb_valid    = cdb_req_w && bus.cdb_gnt;
    assign bus.resp         = cdb_req_w && bus.cdb_gnt;
    assign bus.mul_start    = start_q && (state_q == S_MUL_WAIT) && !bus.flush;
    assign bus.div_start    = start_q && (state_q == S_DIV_WAIT) && !bus.flush;
    assign bus.mul_a_signed = mul_a_signed_q;
    assign bus.mul_b_signed = mul_b_signed_q;
    assign bus.div_signed   = div_signed_q;
    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.cdb_tag      = tag_q;
    assign bus.cdb_data     = result_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard bench for mult_div_ctrl: directed RV32M ops against behavioural mul/div units.
// Expected CDB results are queued at issue and checked by a monitor whenever cdb_valid fires.
module tb_mult_div_ctrl;
    import mult_div_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 5;

    typedef struct packed {
        logic [1:0]  tag;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    exp_t sb_q[$];
    int   mul_starts;
    int   div_starts;
    int   div_dones;
    logic last_a_s;
    logic last_b_s;
    logic last_div_s;

    mult_div_ctrl_if #(.TAG_W(2)) bus ();

    mult_div_ctrl #(.ROB_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required to finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Behavioural multiplier: honours the signedness flags sampled with mul_start.
    initial begin
        logic signed [65:0] ea, eb, pr;
        bus.mul_done    = 1'b0;
        bus.mul_product = '0;
        forever begin
            @(negedge clk);
            if (bus.mul_start) begin
                ea = bus.mul_a_signed ? {{34{bus.op_a[31]}}, bus.op_a} : {34'd0, bus.op_a};
                eb = bus.mul_b_signed ? {{34{bus.op_b[31]}}, bus.op_b} : {34'd0, bus.op_b};
                pr = ea * eb;
                repeat (MUL_LAT) @(posedge clk);
                #1 bus.mul_done = 1'b1;
                bus.mul_product = pr[63:0];
                @(posedge clk);
                #1 bus.mul_done = 1'b0;
            end
        end
    end

    // Behavioural divider with RISC-V corner results so a wrongly started special op stays defined.
    initial begin
        logic [31:0] a, b, q, r;
        bus.div_done = 1'b0;
        bus.div_quot = '0;
        bus.div_rem  = '0;
        forever begin
            @(negedge clk);
            if (bus.div_start) begin
                a = bus.op_a;
                b = bus.op_b;
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else if (bus.div_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = a;
                    r = 32'd0;
                end else if (bus.div_signed) begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                end else begin
                    q = a / b;
                    r = a % b;
                end
                repeat (DIV_LAT) @(posedge clk);
                #1 bus.div_done = 1'b1;
                bus.div_quot = q;
                bus.div_rem  = r;
                @(posedge clk);
                #1 bus.div_done = 1'b0;
            end
        end
    end

    // Monitor: counts unit starts and checks each CDB broadcast against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mul_start) begin
                mul_starts++;
                last_a_s = bus.mul_a_signed;
                last_b_s = bus.mul_b_signed;
            end
            if (bus.div_start) begin
                div_starts++;
                last_div_s = bus.div_signed;
            end
            if (bus.div_done) div_dones++;
            if (bus.cdb_req || bus.cdb_valid || bus.resp)
                check("resp_valid_eq_req_gnt", {bus.resp, bus.cdb_valid}, {2{bus.cdb_req & bus.cdb_gnt}});
            if (bus.cdb_valid) begin
                if (sb_q.size() == 0) begin
                    check("cdb_unexpected", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("cdb_tag", bus.cdb_tag, e.tag);
                    check("cdb_data", bus.cdb_data, e.data);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        check({name, "_ctrl"}, {bus.resp, bus.mul_start, bus.mul_a_signed, bus.mul_b_signed, bus.div_start,
                                bus.div_signed, bus.cdb_req, bus.cdb_valid, bus.cdb_tag}, 0);
        check({name, "_op_a"}, bus.op_a, 0);
        check({name, "_op_b"}, bus.op_b, 0);
        check({name, "_cdb_data"}, bus.cdb_data, 0);
    endtask

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] tag);
        bus.instr_in    = {17'd0, f3, 5'd1, 7'h33};
        bus.tag_dest_in = tag;
        bus.data_A_in   = a;
        bus.data_B_in   = b;
        bus.comp_issue  = 1'b1;
    endtask

    // Issues one op, holds it until resp, optionally withholding the grant for gnt_delay request cycles.
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] tag, input logic [31:0] exp_data,
                          input int gnt_delay, output int lat, output int held, output logic stable);
        logic        got;
        logic [1:0]  t0;
        logic [31:0] d0;
        sb_q.push_back('{tag: tag, data: exp_data});
        @(posedge clk);
        #1 drive_op(f3, a, b, tag);
        bus.cdb_gnt = (gnt_delay == 0);
        lat    = 0;
        held   = 0;
        stable = 1'b1;
        got    = 1'b0;
        t0     = '0;
        d0     = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp) begin
                got = 1'b1;
                break;
            end
            if (bus.cdb_req) begin
                held++;
                if (held == 1) begin
                    t0 = bus.cdb_tag;
                    d0 = bus.cdb_data;
                end else if (bus.cdb_tag !== t0 || bus.cdb_data !== d0) begin
                    stable = 1'b0;
                end
                if (held == gnt_delay) begin
                    @(posedge clk);
                    #1 bus.cdb_gnt = 1'b1;
                end
            end
        end
        check({name, "_resp_seen"}, got, 1);
        @(posedge clk);
        #1 bus.comp_issue = 1'b0;
        bus.cdb_gnt = 1'b1;
    endtask

    initial begin
        int   lat, held, ms0, ds0, dd0;
        logic stable, found, req_seen;
        n_checks     = 0;
        n_pass       = 0;
        mul_starts   = 0;
        div_starts   = 0;
        div_dones    = 0;
        last_a_s     = 1'b0;
        last_b_s     = 1'b0;
        last_div_s   = 1'b0;
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.comp_issue  = 1'b0;
        bus.instr_in    = '0;
        bus.tag_dest_in = '0;
        bus.data_A_in   = '0;
        bus.data_B_in   = '0;
        bus.cdb_gnt     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("post_reset_idle");

        // MUL 7 * -3 = -21.
        ms0 = mul_starts; ds0 = div_starts;
        run_op("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 2'd1, 32'hFFFF_FFEB, 0, lat, held, stable);
        check("mul_start_count", mul_starts - ms0, 1);
        check("mul_no_div_start", div_starts - ds0, 0);
        check("mul_latency", lat, 2 + MUL_LAT + 1);
        check("mul_signed_ab", {last_a_s, last_b_s}, 2'b11);

        run_op("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd2, 32'hFFFF_FFFE, 0, lat, held, stable);
        check("mulhu_signed_ab", {last_a_s, last_b_s}, 2'b00);

        run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 2'd3, 32'hFFFF_FFFF, 0, lat, held, stable);
        check("mulhsu_signed_ab", {last_a_s, last_b_s}, 2'b10);

        // Divide special cases never reach the divider.
        ds0 = div_starts;
        run_op("div_by_zero", F3_DIV, 32'd5, 32'd0, 2'd0, 32'hFFFF_FFFF, 0, lat, held, stable);
        check("div0_latency", lat, 2);
        run_op("remu_by_zero", F3_REMU, 32'd5, 32'd0, 2'd1, 32'd5, 0, lat, held, stable);
        run_op("div_overflow", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'h8000_0000, 0, lat, held, stable);
        run_op("rem_overflow", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 2'd3, 32'd0, 0, lat, held, stable);
        check("special_no_div_start", div_starts - ds0, 0);

        // DIVU 100/7 with the CDB grant withheld for three request cycles.
        ds0 = div_starts;
        run_op("divu_stall", F3_DIVU, 32'd100, 32'd7, 2'd2, 32'd14, 3, lat, held, stable);
        check("divu_req_held", held, 3);
        check("divu_tag_data_stable", stable, 1);
        check("divu_start_count", div_starts - ds0, 1);
        check("divu_unsigned", last_div_s, 0);

        run_op("rem_signed", F3_REM, 32'hFFFF_FFF9, 32'd2, 2'd1, 32'hFFFF_FFFF, 0, lat, held, stable);
        check("rem_signed_flag", last_div_s, 1);

        // Flush two cycles into DIV_WAIT, then a MUL waits for the drained divider.
        dd0 = div_dones;
        @(posedge clk);
        #1 drive_op(F3_DIVU, 32'd100, 32'd7, 2'd2);
        @(posedge clk);
        @(posedge clk);
        #1 bus.flush = 1'b1;
        bus.comp_issue = 1'b0;
        @(negedge clk);
        check("flush_div_wait_quiet", {bus.cdb_req, bus.div_start, bus.resp}, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        sb_q.push_back('{tag: 2'd1, data: 32'd42});
        drive_op(F3_MUL, 32'd6, 32'd7, 2'd1);
        found    = 1'b0;
        req_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.cdb_req) req_seen = 1'b1;
            if (bus.mul_start) begin
                found = 1'b1;
                break;
            end
        end
        check("drain_mul_started", found, 1);
        check("drain_waited_div_done", div_dones - dd0, 1);
        check("drain_no_cdb_req", req_seen, 0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.resp) begin
                found = 1'b1;
                break;
            end
        end
        check("after_drain_mul_resp", found, 1);
        @(posedge clk);
        #1 bus.comp_issue = 1'b0;

        // Flush in RESULT with the grant high: nothing may retire.
        @(posedge clk);
        #1 drive_op(F3_DIV, 32'd5, 32'd0, 2'd1);
        bus.cdb_gnt = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b1;
        @(negedge clk);
        check("flush_result_outputs", {bus.cdb_req, bus.cdb_valid, bus.resp}, 0);
        @(posedge clk);
        #1 bus.flush = 1'b0;
        bus.comp_issue = 1'b0;
        found = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp) found = 1'b1;
        end
        check("flush_result_no_resp", found, 0);

        // Reset in the middle of MUL_WAIT.
        @(posedge clk);
        #1 drive_op(F3_MUL, 32'd3, 32'd3, 2'd3);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        bus.comp_issue = 1'b0;
        @(negedge clk);
        check("pre_reset_busy_op_a", bus.op_a, 3);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("mid_mul_reset");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("reset_no_stray_req", bus.cdb_req, 0);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
